// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of a byte-addressed 32-bit Memory.
//   clock, resetn          : rising-edge clock, asynchronous active-low reset
//   req_*                  : valid/ready request (write, funct3, addr, wdata) from execute
//   rsp_*                  : valid/ready response (extended load data, error flag)
//   mem_read, mem_write    : Memory strobes, never both high
//   mem_address            : word-aligned Memory address
//   bus                    : shared tri-state data bus, driven here only while mem_write=1
module load_store_unit #(
    parameter int ADDR_BITS = 17
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    inout  tri   [31:0] bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic [31:0] address_q, address_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sign_ext;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    // Stores only define SB/SH/SW; loads additionally have the unsigned LBU/LHU.
    assign f3_legal     = req_write ? (req_funct3 <= 3'd2)
                                    : (req_funct3 != 3'd3 && req_funct3[2:1] != 2'b11);
    assign misaligned   = (req_funct3[1:0] == 2'd1 && req_addr[0])
                        | (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    assign out_of_range = (req_addr >> ADDR_BITS) != 32'd0;
    assign req_bad      = !f3_legal || misaligned || out_of_range;

    // Load extraction straight off the bus during READ.
    assign rd_byte   = 8'(bus >> {lane_q, 3'b000});
    assign rd_half   = lane_q[1] ? bus[31:16] : bus[15:0];
    assign sign_ext  = !funct3_q[2];
    assign load_data = funct3_q[1] ? bus
                     : funct3_q[0] ? {{16{sign_ext & rd_half[15]}}, rd_half}
                     :               {{24{sign_ext & rd_byte[7]}}, rd_byte};

    // Sub-word store merge: word_q still holds the store data until READ replaces it.
    assign lane_mask = funct3_q[0] ? (lane_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
                                   : (32'h0000_00FF << {lane_q, 3'b000});
    assign lane_data = funct3_q[0] ? {2{word_q[15:0]}} : {4{word_q[7:0]}};
    assign merged    = (bus & ~lane_mask) | (lane_data & lane_mask);

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        funct3_d  = funct3_q;
        lane_d    = lane_q;
        word_d    = word_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        address_d = address_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d   = req_write;
                    funct3_d  = req_funct3;
                    lane_d    = req_addr[1:0];
                    word_d    = req_wdata;
                    address_d = {req_addr[31:2], 2'b00};
                    rdata_d   = 32'd0;
                    error_d   = req_bad;
                    state_d   = req_bad ? RESP
                              : (req_write && req_funct3 == 3'd2) ? WRITE : READ;
                end
            end
            READ: begin
                state_d = write_q ? WRITE : RESP;
                word_d  = write_q ? merged : word_q;
                rdata_d = write_q ? 32'd0 : load_data;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they are glitch-free.
        req_ready_d = state_d == IDLE;
        rsp_valid_d = state_d == RESP;
        mem_read_d  = state_d == READ;
        mem_write_d = state_d == WRITE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            funct3_q    <= 3'd0;
            lane_q      <= 2'd0;
            word_q      <= 32'd0;
            rdata_q     <= 32'd0;
            error_q     <= 1'b0;
            address_q   <= 32'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            address_q   <= address_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = address_q;
    // Reset clears mem_write_q asynchronously, releasing the bus without a clock edge.
    assign bus         = mem_write_q ? word_q : 32'bz;

endmodule
